// File: rtl/prio_dec_hold_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prio_dec_hold_pkg
// Purpose  : Shared constants, state encoding and the reference decode
//            function for the priority-code decoder and its encoder tests.
// Revision : 1.0 - initial release
// ============================================================================
package prio_dec_hold_pkg;

  localparam int N_REQ  = 12;
  localparam int CODE_W = 4;

  // Handshake states: accepting a code, or holding the decoded vector.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Expands a priority code into a request vector. Code 0 and any code above
  // N_REQ produce an all-zero vector in both modes, so a priority encoder fed
  // with the result returns the original code for every code 0..N_REQ.
  function automatic logic [N_REQ-1:0] dec_vec(input logic [CODE_W-1:0] code,
                                               input logic              thermo);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (thermo) v[i] = (int'(code) > i) && (int'(code) <= N_REQ);
      else        v[i] = (int'(code) == i + 1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_dec_timer.sv
`default_nettype none
// ============================================================================
// Module   : prio_dec_timer
// Purpose  : Loadable down-counter that stops at zero and flags it; times
//            the hold period of each decoded vector.
// Revision : 1.0 - initial release
// ============================================================================
module prio_dec_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset_n)           count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/prio_dec_hold.sv
`default_nettype none
// ============================================================================
// Module   : prio_dec_hold
// Purpose  : Decodes a priority code (valid/ready) into a registered one-hot
//            or thermometer request vector and holds it for HOLD cycles.
//            Out-of-range codes raise a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module prio_dec_hold
  import prio_dec_hold_pkg::*;
#(
  parameter int N    = N_REQ,   // must equal N_REQ (decode function width)
  parameter int W    = CODE_W,  // must equal CODE_W
  parameter int HOLD = 4        // 1..255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] code,
  input  logic         thermo,
  output logic [N-1:0] y,
  output logic         out_valid,
  output logic         err,
  input  logic         err_clr
);

  // A HOLD of 1 still needs a one-bit counter.
  localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

  state_t state, state_nxt;
  logic   accept;
  logic   out_of_range;
  logic   hold_done;

  assign in_ready     = (state == S_IDLE);
  assign accept       = in_valid && in_ready;
  assign out_of_range = (int'(code) > N);

  prio_dec_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (LOAD_VAL),
    .zero     (hold_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state: leave IDLE on acceptance, leave HOLD when the timer expires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_HOLD;
      S_HOLD:  if (hold_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output vector and valid: capture the decode on acceptance (thermo is
  // sampled only here), clear both when the hold expires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      y         <= dec_vec(code, thermo);
      out_valid <= 1'b1;
    end else if ((state == S_HOLD) && hold_done) begin
      y         <= '0;
      out_valid <= 1'b0;
    end
  end

  // Sticky error: an out-of-range acceptance wins over a same-edge clear.
  always_ff @(posedge clk) begin
    if (!reset_n)                    err <= 1'b0;
    else if (accept && out_of_range) err <= 1'b1;
    else if (err_clr)                err <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_dec_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_dec_hold
// Purpose  : Self-checking bench for prio_dec_hold (HOLD=4 and HOLD=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_dec_hold;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, thermo, err_clr;
  logic [3:0]  code;
  logic        in_ready, out_valid, err;
  logic [11:0] y;

  logic        h_in_valid, h_thermo, h_err_clr;
  logic [3:0]  h_code;
  logic        h_in_ready, h_out_valid, h_err;
  logic [11:0] h_y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_dec_hold #(.N(12), .W(4), .HOLD(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .thermo(thermo), .y(y), .out_valid(out_valid),
    .err(err), .err_clr(err_clr)
  );

  prio_dec_hold #(.N(12), .W(4), .HOLD(1)) u_h1 (
    .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .code(h_code), .thermo(h_thermo), .y(h_y), .out_valid(h_out_valid),
    .err(h_err), .err_clr(h_err_clr)
  );

  typedef struct {
    logic [3:0]  code;
    logic        thermo;
    logic [11:0] exp_y;
  } vec_t;

  vec_t vecs[16];

  // Independent priority encoder: index of the highest set bit plus one.
  function automatic int penc(input logic [11:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 12; i++) if (v[i]) r = i + 1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // One-hot sweep 0..12, then a few thermometer codes.
    for (int k = 0; k <= 12; k++) begin
      vecs[k].code   = 4'(k);
      vecs[k].thermo = 1'b0;
      vecs[k].exp_y  = 12'h000;
    end
    vecs[1].exp_y  = 12'h001; vecs[2].exp_y  = 12'h002; vecs[3].exp_y  = 12'h004;
    vecs[4].exp_y  = 12'h008; vecs[5].exp_y  = 12'h010; vecs[6].exp_y  = 12'h020;
    vecs[7].exp_y  = 12'h040; vecs[8].exp_y  = 12'h080; vecs[9].exp_y  = 12'h100;
    vecs[10].exp_y = 12'h200; vecs[11].exp_y = 12'h400; vecs[12].exp_y = 12'h800;
    vecs[13] = '{code: 4'd12, thermo: 1'b1, exp_y: 12'hFFF};
    vecs[14] = '{code: 4'd3,  thermo: 1'b1, exp_y: 12'h007};
    vecs[15] = '{code: 4'd1,  thermo: 1'b1, exp_y: 12'h001};

    // Reset with a code presented: it must not be accepted.
    reset_n = 1'b0; in_valid = 1'b1; code = 4'd5; thermo = 1'b0; err_clr = 1'b0;
    h_in_valid = 1'b0; h_code = 4'd0; h_thermo = 1'b0; h_err_clr = 1'b0;
    step(); step();
    chk("rst_y",        32'(y), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready), 32'h1);
    chk("rst_err",       32'(err), 32'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    chk("post_rst_no_accept", 32'(out_valid), 32'h0);

    // Reset mid-hold: accept code 5, assert reset during the 2nd hold cycle.
    in_valid = 1'b1; code = 4'd5;
    step();
    in_valid = 1'b0;
    chk("mid_y_accept", 32'(y), 32'h010);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_y",         32'(y), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_in_ready",  32'(in_ready), 32'h1);
    chk("mid_rst_err",       32'(err), 32'h0);

    // Table sweep: in_valid stays high, so each code is taken 5 cycles apart.
    for (int v = 0; v < 16; v++) begin
      code = vecs[v].code; thermo = vecs[v].thermo; in_valid = 1'b1;
      step();
      chk($sformatf("v%0d_y", v),        32'(y), 32'(vecs[v].exp_y));
      chk($sformatf("v%0d_roundtrip", v), 32'(penc(y)), 32'(vecs[v].code));
      for (int c = 1; c < 4; c++) begin
        chk($sformatf("v%0d_ov_c%0d", v, c), 32'(out_valid), 32'h1);
        chk($sformatf("v%0d_rdy_c%0d", v, c), 32'(in_ready), 32'h0);
        step();
      end
      chk($sformatf("v%0d_ov_last", v), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_y_held", v),  32'(y), 32'(vecs[v].exp_y));
      step();
      if (v == 15) in_valid = 1'b0;
      chk($sformatf("v%0d_ov_end", v),  32'(out_valid), 32'h0);
      chk($sformatf("v%0d_rdy_end", v), 32'(in_ready), 32'h1);
      chk($sformatf("v%0d_y_end", v),   32'(y), 32'h0);
      chk($sformatf("v%0d_err", v),     32'(err), 32'h0);
    end

    // thermo/code changes during HOLD must not alter the held vector.
    in_valid = 1'b1; code = 4'd7; thermo = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stab_y_c%0d", c), 32'(y), 32'h040);
      thermo = ~thermo; code = 4'(c + 2);
      step();
    end
    chk("stab_end_ov", 32'(out_valid), 32'h0);
    thermo = 1'b0;

    // Out-of-range code 13: zero vector, full hold, sticky err.
    in_valid = 1'b1; code = 4'd13;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("oor_y_c%0d", c),   32'(y), 32'h0);
      chk($sformatf("oor_ov_c%0d", c),  32'(out_valid), 32'h1);
      chk($sformatf("oor_err_c%0d", c), 32'(err), 32'h1);
      step();
    end
    chk("oor_ov_end",  32'(out_valid), 32'h0);
    chk("oor_err_end", 32'(err), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("oor_err_clr", 32'(err), 32'h0);
    chk("oor_clr_ov",  32'(out_valid), 32'h0);

    // Set beats clear on the same edge, then a lone clear works.
    in_valid = 1'b1; code = 4'd15; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("sbc_err", 32'(err), 32'h1);
    chk("sbc_ov",  32'(out_valid), 32'h1);
    step(); step(); step(); step();
    chk("sbc_idle", 32'(in_ready), 32'h1);
    chk("sbc_err_hold", 32'(err), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("sbc_err_clr", 32'(err), 32'h0);

    // HOLD=1 build: single-cycle pulse, then back to IDLE.
    chk("h1_idle_rdy", 32'(h_in_ready), 32'h1);
    h_in_valid = 1'b1; h_code = 4'd7; h_thermo = 1'b0;
    step();
    h_in_valid = 1'b0; h_thermo = 1'b1; h_code = 4'd3;
    chk("h1_y",   32'(h_y), 32'h040);
    chk("h1_ov",  32'(h_out_valid), 32'h1);
    chk("h1_rdy", 32'(h_in_ready), 32'h0);
    step();
    chk("h1_ov_end",  32'(h_out_valid), 32'h0);
    chk("h1_y_end",   32'(h_y), 32'h0);
    chk("h1_rdy_end", 32'(h_in_ready), 32'h1);
    step();
    chk("h1_no_accept", 32'(h_out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prio_dec_hold.md
Name: prio_dec_hold

Overview:
- Inverse of the team's 12-to-4 priority encoder.
- Accepts a 4-bit priority code (0 = none, 1..12 = request index) over a valid/ready handshake and drives a registered 12-bit request vector. The vector is either one-hot or thermometer, selected by a mode input.
- Holds each decoded vector for a fixed number of cycles before accepting the next code.
- Used on the prototyping boards to replay encoder output onto LEDs and to regenerate request vectors for encoder loop-back tests.

Parameters:
- N, 12, number of request lines (output width); code values 1..N are valid.
- W, 4, code width; must satisfy 2**W > N.
- HOLD, 4, cycles out_valid stays high per accepted code; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  code is valid this cycle.
- in_ready  output  1  block can accept a code; combinational = (state == IDLE).
- code  input  W  priority code; 0 = no request, 1..N = index of highest request.
- thermo  input  1  0 = one-hot output, 1 = thermometer output; sampled only at acceptance.
- y  output  N  decoded request vector, registered.
- out_valid  output  1  y is being held.
- err  output  1  sticky flag; set when an out-of-range code (N+1..2**W-1) is accepted.
- err_clr  input  1  clears err.

Behaviour:
- Reset (reset_n low at a rising edge): state = IDLE, y = 0, out_valid = 0, err = 0, hold counter = 0.
  - Reset in the middle of a hold aborts the hold immediately.
  - A code presented in the same cycle as reset is not accepted.
- States:
  - IDLE: in_ready = 1.
  - HOLD: in_ready = 0.
- Acceptance:
  - A code is accepted on a rising edge where in_valid = 1 and state = IDLE.
  - On the following cycle: state = HOLD, out_valid = 1, y = decoded value, counter = HOLD-1.
  - Latency from acceptance edge to y valid is 1 cycle.
- Decode rules, for code k:
  - k in 1..N, one-hot mode: y[k-1] = 1, all other bits 0.
  - k in 1..N, thermometer mode: y[k-1:0] all 1, upper bits 0. Example: k = 12, thermo = 1 gives y = 12'hFFF.
  - k = 0: y = 0 in both modes. This is still a normal hold, with out_valid = 1 for HOLD cycles, and err does not change.
  - k > N: y = 0, a normal hold, and err is set.
- Round-trip property: feeding y through the priority encoder returns k for every k in 0..N, in both modes.
- HOLD state:
  - The counter decrements once per cycle.
  - On the edge where counter = 0: state = IDLE, out_valid = 0, y = 0.
  - out_valid is therefore high for exactly HOLD cycles.
  - Maximum throughput is one code per HOLD+1 cycles.
  - in_valid is ignored during HOLD. The source must keep code stable until in_ready is seen.
- HOLD = 1: out_valid pulses high for a single cycle, then the block returns to IDLE.
- err behaviour:
  - Set on acceptance of an out-of-range code.
  - Cleared by err_clr = 1 at a rising edge.
  - If err_clr and an out-of-range acceptance occur on the same edge, the set wins and err = 1.
  - err_clr has no effect on y, out_valid or state.
- thermo changes while in HOLD do not alter the held y.

Decomposition:
- Shared package holds:
  - constants N_REQ = 12 and CODE_W = 4;
  - a state enum {IDLE, HOLD};
  - a pure function dec_vec(code, thermo) returning an N-bit vector. The encoder tests reuse this function as their reference model.
- One sub-module, prio_dec_timer: a loadable down-counter of width clog2(HOLD). Its interface is load, load value, and a zero flag.
- The handshake FSM, output registers and err logic stay in the top module.

Test Plan:
- Reset mid-hold: accept code 5 and pull reset_n low on the 2nd hold cycle -> next cycle y = 0, out_valid = 0, in_ready = 1, err = 0.
- One-hot sweep, thermo = 0, HOLD = 4: codes 0..12 back to back with in_valid held high -> each y = 1 << (k-1) (0 for k = 0); out_valid high 4 cycles; in_ready low 4 cycles; next acceptance 5 cycles after the previous one.
- Thermometer sweep, thermo = 1: code 12 -> y = 12'hFFF; code 3 -> y = 12'h007; code 1 -> y = 12'h001. Every y passed through the priority encoder returns k.
- Invalid code: code 13 -> y = 0, out_valid high 4 cycles, err = 1 from the cycle after acceptance. Then pulse err_clr for one cycle with no new code -> err = 0.
- Set beats clear: pulse err_clr on the same edge as acceptance of code 15 -> err = 1. A later err_clr alone -> err = 0.
- Hold-time stability, HOLD = 1 build: accept code 7 -> out_valid is a 1-cycle pulse with y = 12'h040. Toggling thermo and code during HOLD leaves y unchanged.
